clint_cbus_slave: RTL
=====================

// Module: clint_cbus_slave
// PURPOSE
//  Core-local interruptor (CLINT) on the cache bus, directly downstream of the top's
//  oreq/oresp pair and upstream of its trint/swint inputs.
//  Holds msip, mtime and mtimecmp as memory-mapped registers and answers single-beat CBus reads/writes.
//  Produces the timer (trint) and software (swint) interrupt levels fed back into the core.
// PARAMETERS
//  BASE_ADDR  64'h0200_0000  CLINT base; window is BASE_ADDR..BASE_ADDR+64'hFFFF
//  TICK_DIV   1              clk cycles per mtime increment (>=1)
// PORTS
//  clk       in   1          clock, all state updates on posedge
//  reset     in   1          asynchronous, active-low
//  ireq      in   cbus_req_t  request (valid,is_write,size,addr,strobe,data,len,burst)
//  iresp     out  cbus_resp_t response (ready,last,data)
//  trint     out  1          timer interrupt level
//  swint     out  1          software interrupt level
// BEHAVIOUR
//  - Reset (reset==0, async): mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, tick counter=0, state=IDLE;
//    iresp.ready=0, iresp.last=0, iresp.data=0, trint=0, swint=0.
//  - Register map (offset = addr-BASE_ADDR, 8-byte aligned, addr[2:0] ignored):
//    0x0000 msip (bit0 only, bits 63:1 read 0); 0x4000 mtimecmp; 0xBFF8 mtime.
//  - Other offsets in window, or addr outside window: read data 0, write dropped, still acked.
//  - FSM IDLE->RESP on posedge with ireq.valid=1; request decoded and write committed on that edge,
//    read data captured from pre-write register value on the same edge.
//  - RESP: iresp.ready=1, iresp.last=1, iresp.data=captured value; always RESP->IDLE next edge.
//  - Latency: exactly one cycle from valid sampled to ready; one transaction per 2 cycles max.
//  - Master holds ireq stable until ready; ireq changes during RESP are ignored.
//  - len/burst ignored: every request answered with exactly one beat, last=1.
//  - Writes honour strobe bytewise (strobe[i] -> data[8i+7:8i]); size not used for masking.
//  - msip write updates bit0 only from data[0] when strobe[0]=1.
//  - Tick counter counts 0..TICK_DIV-1; mtime+=1 on wrap (64-bit, wraps 2^64-1 -> 0 silently).
//  - Same-edge mtime write and tick: written bytes take write value, unwritten bytes keep
//    pre-increment value (no increment applied that edge).
//  - trint = registered (mtime >= mtimecmp), unsigned; updates one cycle after the compared values.
//  - swint = msip[0] registered; visible the cycle after the write edge.
//  - Reset asserted mid-transaction: FSM to IDLE, ready drops immediately, transaction lost.
// CONFIGURATION
//  CLINT_MTIME_WRITE_EN defined: mtime writable per rules above.
//  CLINT_MTIME_WRITE_EN undefined: mtime read-only; writes to 0xBFF8 acked and dropped,
//    mtime only advances by tick.
// TESTING
//  1. Release reset, TICK_DIV=1, idle 10 cycles; read 0xBFF8 -> data in [9..12], ready 1 cycle after valid, last=1.
//  2. Write mtimecmp=0x20, strobe=0xFF, from reset -> trint=0 before mtime reaches 0x20,
//     trint=1 one cycle after mtime==0x20; write mtimecmp=all-ones -> trint=0 next-but-one cycle.
//  3. Write msip data=0x3 strobe=0x01 -> swint=1, read msip=0x1; write data=0 -> swint=0.
//  4. Write mtimecmp data=0xAABB..., strobe=0x0F over 0xFFFF... -> read 0xFFFF_FFFF_AABB_CCDD form
//     (upper 4 bytes unchanged).
//  5. Read addr BASE_ADDR+0x100 and addr 0x8000_0000 -> data 0, ready/last=1; write there -> no reg change.
//  6. With CLINT_MTIME_WRITE_EN: write mtime=64'hFFFF_FFFF_FFFF_FFFE -> two ticks later reads 0;
//     without it: same write leaves mtime counting from its prior value.

Source files
------------

// File: rtl/clint_cbus_slave_if.sv
// Cache-bus (CBus) request/response bundle between a master and the CLINT.
// The master drives the ireq_* fields and the slave drives the iresp_* fields.
// A request is single-beat: len/burst/size travel with it but the CLINT ignores them.
interface clint_cbus_slave_if;
  logic        ireq_valid;
  logic        ireq_is_write;
  logic [2:0]  ireq_size;
  logic [63:0] ireq_addr;
  logic [7:0]  ireq_strobe;
  logic [63:0] ireq_data;
  logic [7:0]  ireq_len;
  logic [1:0]  ireq_burst;
  logic        iresp_ready;
  logic        iresp_last;
  logic [63:0] iresp_data;

  modport master (
    output ireq_valid, ireq_is_write, ireq_size, ireq_addr,
           ireq_strobe, ireq_data, ireq_len, ireq_burst,
    input  iresp_ready, iresp_last, iresp_data
  );

  modport slave (
    input  ireq_valid, ireq_is_write, ireq_size, ireq_addr,
           ireq_strobe, ireq_data, ireq_len, ireq_burst,
    output iresp_ready, iresp_last, iresp_data
  );
endinterface

// File: rtl/clint_cbus_slave.sv
// Core-local interruptor on the cache bus.
// Holds msip (0x0000), mtimecmp (0x4000) and mtime (0xBFF8) relative to BASE_ADDR and
// answers every request with one response beat exactly one cycle after it is accepted.
// trint/swint are registered interrupt levels fed back to the core.
// Optional feature: define CLINT_MTIME_WRITE_EN to make mtime writable over the bus;
// without it mtime is read-only and only advances with the tick divider.
module clint_cbus_slave #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int unsigned TICK_DIV  = 32'd1
) (
  input  logic              clk,
  input  logic              reset,
  clint_cbus_slave_if.slave cbus,
  output logic              trint,
  output logic              swint
);

  localparam int unsigned     CNT_W     = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 32'd1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 32'd1);
  localparam logic [12:0]     OFF_MSIP  = 13'h0000;  // 0x0000 >> 3
  localparam logic [12:0]     OFF_CMP   = 13'h0800;  // 0x4000 >> 3
  localparam logic [12:0]     OFF_MTIME = 13'h17FF;  // 0xBFF8 >> 3

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  // Byte-lane merge: strobed lanes take the new value, the rest keep the old one.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [7:0]  strb);
    logic [63:0] res;
    res = old_v;
    for (int i = 0; i < 32'sd8; i++) begin
      if (strb[i]) begin
        res[32'sd8*i +: 8] = new_v[32'sd8*i +: 8];
      end else begin
        res[32'sd8*i +: 8] = old_v[32'sd8*i +: 8];
      end
    end
    return res;
  endfunction

  state_t            state_r, state_next_s;
  logic              accept_s, wr_s;
  logic [63:0]       off_s;
  logic              in_win_s, hit_msip_s, hit_cmp_s, hit_mtime_s;
  logic              msip_we_s, cmp_we_s, mtime_we_s;
  logic              tick_s;
  logic [CNT_W-1:0]  tick_cnt_r;
  logic              msip_r, msip_next_s;
  logic [63:0]       mtimecmp_r, mtimecmp_next_s;
  logic [63:0]       mtime_r, mtime_next_s;
  logic [63:0]       rdata_s;
  logic              ready_r, last_r;
  logic [63:0]       data_r;
  logic              trint_r, swint_r;
  logic              unused_s;

  // Address decode: the 64 KiB window, 8-byte aligned registers, addr[2:0] ignored.
  assign off_s       = cbus.ireq_addr - BASE_ADDR;
  assign in_win_s    = (cbus.ireq_addr >= BASE_ADDR) && (off_s[63:16] == 48'h0);
  assign hit_msip_s  = in_win_s && (off_s[15:3] == OFF_MSIP);
  assign hit_cmp_s   = in_win_s && (off_s[15:3] == OFF_CMP);
  assign hit_mtime_s = in_win_s && (off_s[15:3] == OFF_MTIME);

  assign wr_s      = accept_s && cbus.ireq_is_write;
  assign msip_we_s = wr_s && hit_msip_s && cbus.ireq_strobe[0];
  assign cmp_we_s  = wr_s && hit_cmp_s;
`ifdef CLINT_MTIME_WRITE_EN
  assign mtime_we_s = wr_s && hit_mtime_s;
`else
  assign mtime_we_s = 1'b0;
`endif

  assign tick_s = (tick_cnt_r == TICK_LAST);

  // Single-beat protocol: size, len and burst never affect the response.
  assign unused_s = ^{cbus.ireq_size, cbus.ireq_len, cbus.ireq_burst, off_s[2:0]};

  // FSM next state: accept in IDLE, always return to IDLE after one response cycle.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (cbus.ireq_valid) begin
          state_next_s = RESP;
          accept_s     = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      RESP: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Read mux over the pre-write register values; unmapped offsets read zero.
  always_comb begin
    rdata_s = 64'h0;
    if (hit_msip_s) begin
      rdata_s = {63'h0, msip_r};
    end else if (hit_cmp_s) begin
      rdata_s = mtimecmp_r;
    end else if (hit_mtime_s) begin
      rdata_s = mtime_r;
    end else begin
      rdata_s = 64'h0;
    end
  end

  // Next register values; a bus write to mtime overrides that edge's tick increment.
  always_comb begin
    msip_next_s     = msip_r;
    mtimecmp_next_s = mtimecmp_r;
    mtime_next_s    = mtime_r;
    if (msip_we_s) begin
      msip_next_s = cbus.ireq_data[0];
    end else begin
      msip_next_s = msip_r;
    end
    if (cmp_we_s) begin
      mtimecmp_next_s = merge_bytes(mtimecmp_r, cbus.ireq_data, cbus.ireq_strobe);
    end else begin
      mtimecmp_next_s = mtimecmp_r;
    end
    if (mtime_we_s) begin
      mtime_next_s = merge_bytes(mtime_r, cbus.ireq_data, cbus.ireq_strobe);
    end else if (tick_s) begin
      mtime_next_s = mtime_r + 64'd1;
    end else begin
      mtime_next_s = mtime_r;
    end
  end

  // Tick prescaler: counts 0..TICK_DIV-1, mtime advances on the wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_r <= {CNT_W{1'b0}};
    end else if (tick_s) begin
      tick_cnt_r <= {CNT_W{1'b0}};
    end else begin
      tick_cnt_r <= tick_cnt_r + CNT_W'(32'd1);
    end
  end

  // Architectural registers and FSM state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      msip_r     <= 1'b0;
      mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
      mtime_r    <= 64'h0;
    end else begin
      state_r    <= state_next_s;
      msip_r     <= msip_next_s;
      mtimecmp_r <= mtimecmp_next_s;
      mtime_r    <= mtime_next_s;
    end
  end

  // Registered response beat: valid for exactly the cycle after acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_r <= 1'b0;
      last_r  <= 1'b0;
      data_r  <= 64'h0;
    end else if (accept_s) begin
      ready_r <= 1'b1;
      last_r  <= 1'b1;
      data_r  <= rdata_s;
    end else begin
      ready_r <= 1'b0;
      last_r  <= 1'b0;
      data_r  <= 64'h0;
    end
  end

  // Interrupt levels: timer compares current registers, software follows the msip update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trint_r <= 1'b0;
      swint_r <= 1'b0;
    end else begin
      trint_r <= (mtime_r >= mtimecmp_r);
      swint_r <= msip_next_s;
    end
  end

  assign cbus.iresp_ready = ready_r;
  assign cbus.iresp_last  = last_r;
  assign cbus.iresp_data  = data_r;
  assign trint            = trint_r;
  assign swint            = swint_r;

endmodule
